c157x_sd_arbiter: RTL and testbench
===================================

C157X_SD_ARBITER -- requirements
Module: c157x_sd_arbiter

Interface
REQ-001 Parameter NDRV, default 4: number of track-controller requesters, 2..4.
REQ-002 Parameter TMO, default 24'hFFFFFF: number of cycles to wait for the host sd_ack rise before timeout.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req_lba, input, NDRV*32: per-requester LBA; slice i is [32*i+31:32*i].
REQ-006 Port req_rd, input, NDRV: per-requester read request, held until that requester's ack.
REQ-007 Port req_wr, input, NDRV: per-requester write request, held until that requester's ack.
REQ-008 Port req_ack, output, NDRV: per-requester acknowledge.
REQ-009 Port sd_lba, output, 32: LBA sent to the host.
REQ-010 Port sd_rd, output, 1: read request to the host.
REQ-011 Port sd_wr, output, 1: write request to the host.
REQ-012 Port sd_ack, input, 1: host acknowledge; high for the whole transfer; same clock domain, not synchronised.
REQ-013 Port sd_sel, output, 2: index of the granted requester, used for sector-buffer steering.
REQ-014 Port busy, output, 1: high while any grant is active.
REQ-015 Port timeout, output, 1: one-cycle pulse on timeout.
REQ-016 Port timeout_drv, output, 2: index of the requester that timed out; valid while timeout is high.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, WAIT_ACK, XFER.
REQ-018 IDLE SHALL grant only when sd_ack=0 and at least one requester i has req_rd[i]|req_wr[i]=1.
- Winner is chosen round-robin, searching from last+1 modulo NDRV.
REQ-019 On a grant, the same clock edge SHALL:
- latch sd_lba = req_lba slice of the winner and sd_sel = winner;
- set sd_wr=1 if req_wr[winner]=1, else set sd_rd=1;
- set busy=1 and load the timeout counter to 0;
- enter WAIT_ACK.
- Net effect: sd_rd/sd_wr rise one cycle after the request is seen.
REQ-020 If req_rd and req_wr are both high for the winner, write SHALL take precedence; the read stays pending for a later grant.
REQ-021 sd_rd, sd_wr, sd_lba, sd_sel, busy, timeout and timeout_drv SHALL be registered outputs.
REQ-022 req_ack[i] SHALL equal sd_ack & busy & (sd_sel==i), combinationally; all other req_ack bits SHALL be 0.
REQ-023 In WAIT_ACK, sd_ack=1 SHALL clear sd_rd and sd_wr on the next edge and enter XFER.
REQ-024 In WAIT_ACK, if the granted requester drops both req_rd and req_wr before sd_ack rises (abort):
- clear sd_rd, sd_wr and busy;
- set last = sd_sel;
- return to IDLE, with no timeout pulse.
REQ-025 In WAIT_ACK, the counter SHALL increment every cycle. When it reaches TMO with sd_ack still 0:
- clear sd_rd, sd_wr and busy;
- pulse timeout for 1 cycle with timeout_drv = sd_sel;
- set last = sd_sel and return to IDLE.
- The requester's request remains pending and is re-arbitrated.
REQ-026 In XFER, the fall of sd_ack SHALL clear busy, set last = sd_sel and return to IDLE.
- Requester changes are ignored during XFER.
- There is no timeout in XFER.
REQ-027 sd_sel and sd_lba SHALL hold their granted values from grant until the next grant.
REQ-028 At least one IDLE cycle SHALL separate consecutive grants.
REQ-029 A requester that re-asserts immediately after its ack falls SHALL NOT be granted ahead of other pending requesters.
REQ-030 Requests from index >= NDRV SHALL never be granted.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for clk:
- set state=IDLE;
- clear sd_rd, sd_wr, busy and timeout;
- set sd_lba=0, sd_sel=0, timeout_drv=0 and counter=0;
- set last=NDRV-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer; req_ack SHALL go 0 immediately because busy=0.
REQ-033 After reset release, a host sd_ack still high SHALL block new grants until it falls (REQ-018).

Verification
REQ-034 Single read: req_rd[1]=1, lba 0x00000512 -> next cycle sd_rd=1, sd_lba=0x512, sd_sel=1.
- Then sd_ack high 5 cycles -> req_ack[1] high 5 cycles and sd_rd=0 one cycle after the ack rise.
- On the ack fall, busy=0.
REQ-035 Round-robin: req_rd[0] and req_rd[2] held high continuously after reset.
- Expected grant order: 0, 2, 0, 2; never 0, 0.
REQ-036 Write priority: req_rd[3]=1 and req_wr[3]=1.
- First grant drives sd_wr=1, sd_rd=0; the next grant to 3 drives sd_rd=1.
REQ-037 Timeout: TMO=16, req_wr[0]=1, sd_ack held 0.
- timeout pulses 1 cycle with timeout_drv=0, 16 cycles after the grant.
- Then sd_wr=0 and busy=0, and requester 0 is re-granted.
REQ-038 Abort: req_rd[2] dropped 3 cycles after grant, before any ack.
- sd_rd=0 and state IDLE next cycle, no timeout pulse, req_ack all 0.
REQ-039 Async reset mid-XFER: assert reset_n=0 between clock edges.
- Outputs clear without waiting for clk.
- With sd_ack still high after release, no grant occurs until sd_ack=0.

Source files
------------

// File: rtl/c157x_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : c157x_sd_arbiter_if
//  Brief    : Requester-side and host-side signal bundle for c157x_sd_arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface c157x_sd_arbiter_if #(
    parameter int NDRV = 4
);
    logic [NDRV*32-1:0] req_lba;
    logic [NDRV-1:0]    req_rd;
    logic [NDRV-1:0]    req_wr;
    logic [NDRV-1:0]    req_ack;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack;
    logic [1:0]         sd_sel;
    logic               busy;
    logic               timeout;
    logic [1:0]         timeout_drv;

    // Arbiter view
    modport master (
        input  req_lba, req_rd, req_wr, sd_ack,
        output req_ack, sd_lba, sd_rd, sd_wr, sd_sel, busy, timeout, timeout_drv
    );

    // Requesters plus host view
    modport slave (
        output req_lba, req_rd, req_wr, sd_ack,
        input  req_ack, sd_lba, sd_rd, sd_wr, sd_sel, busy, timeout, timeout_drv
    );
endinterface
`default_nettype wire

// File: rtl/c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : c157x_sd_arbiter
//  Brief    : Round-robin arbiter of up to four track controllers onto one
//             SD host port, with ack timeout and requester abort.
//  Revision : 1.0  initial release
// ============================================================================
module c157x_sd_arbiter #(
    parameter int          NDRV = 4,
    parameter logic [23:0] TMO  = 24'hFFFFFF
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    c157x_sd_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_XFER     = 2'd2
    } state_t;

    localparam logic [23:0] c_TMO_LAST = TMO - 24'd1;
    localparam logic [1:0]  c_LAST_RST = 2'(NDRV - 1);

    state_t      r_state;
    logic        r_sd_rd;
    logic        r_sd_wr;
    logic [31:0] r_sd_lba;
    logic [1:0]  r_sd_sel;
    logic        r_busy;
    logic        r_timeout;
    logic [1:0]  r_timeout_drv;
    logic [23:0] r_cnt;
    logic [1:0]  r_last;

    state_t      w_nxt_state;
    logic        w_nxt_rd;
    logic        w_nxt_wr;
    logic [31:0] w_nxt_lba;
    logic [1:0]  w_nxt_sel;
    logic        w_nxt_busy;
    logic        w_nxt_timeout;
    logic [1:0]  w_nxt_timeout_drv;
    logic [23:0] w_nxt_cnt;
    logic [1:0]  w_nxt_last;

    logic [NDRV-1:0] w_pend;
    logic            w_found_hi;
    logic            w_found_lo;
    logic [1:0]      w_win_hi;
    logic [1:0]      w_win_lo;
    logic            w_found;
    logic [1:0]      w_win;
    logic [31:0]     w_win_lba;
    logic            w_win_wr;
    logic            w_sel_pend;

    assign w_pend = bus.req_rd | bus.req_wr;

    // Round-robin: first pending index above last, else first at or below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_sel_pend = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (w_pend[i] && (i > int'(r_last)) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_win_hi   = 2'(i);
            end
            if (w_pend[i] && (i <= int'(r_last)) && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = 2'(i);
            end
            if (2'(i) == r_sd_sel) begin
                w_sel_pend = w_pend[i];
            end
        end
    end

    assign w_found = w_found_hi | w_found_lo;
    assign w_win   = w_found_hi ? w_win_hi : w_win_lo;

    always_comb begin
        w_win_lba = '0;
        w_win_wr  = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (2'(i) == w_win) begin
                w_win_lba = bus.req_lba[32*i +: 32];
                w_win_wr  = bus.req_wr[i];
            end
        end
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_rd          = r_sd_rd;
        w_nxt_wr          = r_sd_wr;
        w_nxt_lba         = r_sd_lba;
        w_nxt_sel         = r_sd_sel;
        w_nxt_busy        = r_busy;
        w_nxt_timeout     = 1'b0;
        w_nxt_timeout_drv = r_timeout_drv;
        w_nxt_cnt         = r_cnt;
        w_nxt_last        = r_last;
        case (r_state)
            S_IDLE: begin
                // A host ack left high (e.g. across reset) blocks all grants.
                if (!bus.sd_ack && w_found) begin
                    w_nxt_lba   = w_win_lba;
                    w_nxt_sel   = w_win;
                    w_nxt_wr    = w_win_wr;
                    w_nxt_rd    = !w_win_wr;
                    w_nxt_busy  = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                w_nxt_cnt = r_cnt + 24'd1;
                if (bus.sd_ack) begin
                    w_nxt_rd    = 1'b0;
                    w_nxt_wr    = 1'b0;
                    w_nxt_state = S_XFER;
                end else if (!w_sel_pend) begin
                    w_nxt_rd    = 1'b0;
                    w_nxt_wr    = 1'b0;
                    w_nxt_busy  = 1'b0;
                    w_nxt_last  = r_sd_sel;
                    w_nxt_state = S_IDLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_nxt_rd          = 1'b0;
                    w_nxt_wr          = 1'b0;
                    w_nxt_busy        = 1'b0;
                    w_nxt_timeout     = 1'b1;
                    w_nxt_timeout_drv = r_sd_sel;
                    w_nxt_last        = r_sd_sel;
                    w_nxt_state       = S_IDLE;
                end
            end
            S_XFER: begin
                if (!bus.sd_ack) begin
                    w_nxt_busy  = 1'b0;
                    w_nxt_last  = r_sd_sel;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_sd_rd       <= 1'b0;
            r_sd_wr       <= 1'b0;
            r_sd_lba      <= '0;
            r_sd_sel      <= '0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_timeout_drv <= '0;
            r_cnt         <= '0;
            r_last        <= c_LAST_RST;
        end else begin
            r_state       <= w_nxt_state;
            r_sd_rd       <= w_nxt_rd;
            r_sd_wr       <= w_nxt_wr;
            r_sd_lba      <= w_nxt_lba;
            r_sd_sel      <= w_nxt_sel;
            r_busy        <= w_nxt_busy;
            r_timeout     <= w_nxt_timeout;
            r_timeout_drv <= w_nxt_timeout_drv;
            r_cnt         <= w_nxt_cnt;
            r_last        <= w_nxt_last;
        end
    end

    assign bus.sd_rd       = r_sd_rd;
    assign bus.sd_wr       = r_sd_wr;
    assign bus.sd_lba      = r_sd_lba;
    assign bus.sd_sel      = r_sd_sel;
    assign bus.busy        = r_busy;
    assign bus.timeout     = r_timeout;
    assign bus.timeout_drv = r_timeout_drv;

    generate
        for (genvar gi = 0; gi < NDRV; gi++) begin : g_ack
            assign bus.req_ack[gi] = bus.sd_ack & r_busy & (r_sd_sel == 2'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c157x_sd_arbiter
//  Brief    : Directed self-checking bench for c157x_sd_arbiter (NDRV=4, TMO=16)
//  Revision : 1.0  initial release
// ============================================================================
module tb_c157x_sd_arbiter;

    localparam int NDRV = 4;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    c157x_sd_arbiter_if #(.NDRV(NDRV)) bif ();

    c157x_sd_arbiter #(
        .NDRV (NDRV),
        .TMO  (24'd16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock, then check the freshly granted outputs.
    task automatic do_grant(input logic [1:0] sel, input logic rd, input logic wr,
                            input logic [31:0] lba);
        tick();
        chk("grant_sel",  32'(bif.sd_sel), 32'(sel));
        chk("grant_rd",   32'(bif.sd_rd),  32'(rd));
        chk("grant_wr",   32'(bif.sd_wr),  32'(wr));
        chk("grant_lba",  bif.sd_lba,      lba);
        chk("grant_busy", 32'(bif.busy),   32'd1);
    endtask

    // One-cycle ack pulse; clr drops the requester bits once the ack is seen.
    task automatic do_xfer(input logic [3:0] exp_ack, input logic [3:0] clr);
        bif.sd_ack = 1'b1;
        #1;
        chk("xfer_req_ack", 32'(bif.req_ack), 32'(exp_ack));
        tick();
        chk("xfer_rd_clr", 32'(bif.sd_rd), 32'd0);
        chk("xfer_wr_clr", 32'(bif.sd_wr), 32'd0);
        bif.req_rd = bif.req_rd & ~clr;
        bif.req_wr = bif.req_wr & ~clr;
        bif.sd_ack = 1'b0;
        tick();
        chk("xfer_busy_clr", 32'(bif.busy),    32'd0);
        chk("xfer_ack_clr",  32'(bif.req_ack), 32'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        bif.req_lba = '0;
        bif.req_rd  = '0;
        bif.req_wr  = '0;
        bif.sd_ack  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd",   32'(bif.sd_rd),   32'd0);
        chk("rst_wr",   32'(bif.sd_wr),   32'd0);
        chk("rst_busy", 32'(bif.busy),    32'd0);
        chk("rst_tmo",  32'(bif.timeout), 32'd0);
        chk("rst_sel",  32'(bif.sd_sel),  32'd0);
        chk("rst_lba",  bif.sd_lba,       32'd0);
        reset_n = 1'b1;

        // Single read on requester 1 with a 5-cycle ack
        bif.req_lba[32*1 +: 32] = 32'h0000_0512;
        bif.req_rd[1]           = 1'b1;
        do_grant(2'd1, 1'b1, 1'b0, 32'h0000_0512);
        bif.sd_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rd1_req_ack", 32'(bif.req_ack), 32'h2);
            tick();
            chk("rd1_sd_rd", 32'(bif.sd_rd), 32'd0);
            if (i == 0) bif.req_rd[1] = 1'b0;
            if (i < 4)  chk("rd1_busy_hold", 32'(bif.busy), 32'd1);
        end
        bif.sd_ack = 1'b0;
        #1;
        chk("rd1_ack_fall", 32'(bif.req_ack), 32'd0);
        tick();
        chk("rd1_busy_clr", 32'(bif.busy), 32'd0);

        // Round-robin between 0 and 2 from a fresh reset
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        bif.req_lba[32*0 +: 32] = 32'h0000_0A00;
        bif.req_lba[32*2 +: 32] = 32'h0000_0C02;
        bif.req_rd[0] = 1'b1;
        bif.req_rd[2] = 1'b1;
        do_grant(2'd0, 1'b1, 1'b0, 32'h0000_0A00);
        do_xfer(4'b0001, 4'b0000);
        do_grant(2'd2, 1'b1, 1'b0, 32'h0000_0C02);
        do_xfer(4'b0100, 4'b0000);
        do_grant(2'd0, 1'b1, 1'b0, 32'h0000_0A00);
        do_xfer(4'b0001, 4'b0000);
        do_grant(2'd2, 1'b1, 1'b0, 32'h0000_0C02);
        do_xfer(4'b0100, 4'b0101);

        // Write takes precedence over a simultaneous read on requester 3
        bif.req_lba[32*3 +: 32] = 32'hABCD_0003;
        bif.req_rd[3] = 1'b1;
        bif.req_wr[3] = 1'b1;
        do_grant(2'd3, 1'b0, 1'b1, 32'hABCD_0003);
        bif.sd_ack = 1'b1;
        tick();
        bif.req_wr[3] = 1'b0;
        bif.sd_ack    = 1'b0;
        tick();
        chk("wp_busy_clr", 32'(bif.busy), 32'd0);
        do_grant(2'd3, 1'b1, 1'b0, 32'hABCD_0003);
        do_xfer(4'b1000, 4'b1000);

        // Timeout on requester 0 with the host silent
        bif.req_lba[32*0 +: 32] = 32'h0000_1000;
        bif.req_wr[0] = 1'b1;
        do_grant(2'd0, 1'b0, 1'b1, 32'h0000_1000);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("tmo_quiet", 32'(bif.timeout), 32'd0);
        end
        tick();
        chk("tmo_pulse", 32'(bif.timeout),     32'd1);
        chk("tmo_drv",   32'(bif.timeout_drv), 32'd0);
        chk("tmo_wr",    32'(bif.sd_wr),       32'd0);
        chk("tmo_busy",  32'(bif.busy),        32'd0);
        do_grant(2'd0, 1'b0, 1'b1, 32'h0000_1000);
        chk("tmo_one_cycle", 32'(bif.timeout), 32'd0);
        do_xfer(4'b0001, 4'b0001);

        // Abort: requester 2 withdraws three cycles after its grant
        bif.req_lba[32*2 +: 32] = 32'h0000_2222;
        bif.req_rd[2] = 1'b1;
        do_grant(2'd2, 1'b1, 1'b0, 32'h0000_2222);
        tick();
        tick();
        tick();
        bif.req_rd[2] = 1'b0;
        tick();
        chk("abort_rd",      32'(bif.sd_rd),   32'd0);
        chk("abort_busy",    32'(bif.busy),    32'd0);
        chk("abort_tmo",     32'(bif.timeout), 32'd0);
        chk("abort_req_ack", 32'(bif.req_ack), 32'd0);
        tick();
        chk("abort_idle",    32'(bif.busy),    32'd0);
        chk("abort_sel_hold", 32'(bif.sd_sel), 32'd2);
        chk("abort_lba_hold", bif.sd_lba,      32'h0000_2222);

        // Asynchronous reset in the middle of a transfer
        bif.req_lba[32*3 +: 32] = 32'h0000_3333;
        bif.req_rd[3] = 1'b1;
        do_grant(2'd3, 1'b1, 1'b0, 32'h0000_3333);
        bif.sd_ack = 1'b1;
        tick();
        chk("ar_req_ack", 32'(bif.req_ack), 32'h8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy",    32'(bif.busy),    32'd0);
        chk("ar_sel",     32'(bif.sd_sel),  32'd0);
        chk("ar_lba",     bif.sd_lba,       32'd0);
        chk("ar_req_ack", 32'(bif.req_ack), 32'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        bif.req_rd[1] = 1'b1;
        bif.req_lba[32*1 +: 32] = 32'h0000_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_blocked", 32'(bif.busy), 32'd0);
        end
        bif.sd_ack = 1'b0;
        do_grant(2'd1, 1'b1, 1'b0, 32'h0000_1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
